// File: rtl/spi_xfer_arbiter_if.sv
// rtl/spi_xfer_arbiter_if.sv - APB bus between the SPI transfer arbiter and the APB-SPI bridge
interface spi_xfer_arbiter_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin APB sequencer sharing one APB-SPI bridge (write, poll, read per job)
// Optional poll timeout: SPI_ARB_TIMEOUT_EN
module spi_xfer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1024
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  spi_xfer_arbiter_if.master        apb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_ACCESS, S_GAP, S_ST_SETUP,
    S_ST_ACCESS, S_RD_SETUP, S_RD_ACCESS, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               found;
  logic [IDX_W-1:0]   gidx;
  logic [31:0]        paddr, pwdata;
  logic               psel, penable, pwrite;
  logic               unused_prdata;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int PC_W = $clog2(MAX_POLLS + 1);
  logic [PC_W-1:0] poll_q, poll_d;
  logic            rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign apb.PADDR   = paddr;
  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PWRITE  = pwrite;
  assign apb.PWDATA  = pwdata;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != S_IDLE);
  assign unused_prdata = ^apb.PRDATA;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found = 1'b1;
        gidx  = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_d       = tx_q;
    rsp_data_d = rsp_data_q;
    gap_d      = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    poll_d     = poll_q;
    rsp_err_d  = rsp_err_q;
`endif
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    done    = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = gidx;
          tx_d    = req_data[gidx*DATA_W +: DATA_W];
          ptr_d   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          poll_d  = '0;
`endif
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        psel    = 1'b1;
        penable = (state_q == S_WR_ACCESS);
        pwrite  = 1'b1;
        pwdata  = 32'(tx_q);
        if (state_q == S_WR_SETUP) state_d = S_WR_ACCESS;
        else if (apb.PREADY) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_ST_SETUP;
        else gap_d = gap_q + 1'b1;
      end
      S_ST_SETUP, S_ST_ACCESS: begin
        psel    = 1'b1;
        penable = (state_q == S_ST_ACCESS);
        paddr   = 32'h4;
        if (state_q == S_ST_SETUP) state_d = S_ST_ACCESS;
        else if (apb.PREADY) begin
          gap_d = '0;
`ifdef SPI_ARB_TIMEOUT_EN
          poll_d = poll_q + 1'b1;
          if (apb.PRDATA[0] && (poll_d == PC_W'(MAX_POLLS))) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_DONE;
          end else
`endif
          if (apb.PRDATA[0]) state_d = S_GAP;
          else state_d = S_RD_SETUP;
        end
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        psel    = 1'b1;
        penable = (state_q == S_RD_ACCESS);
        if (state_q == S_RD_SETUP) state_d = S_RD_ACCESS;
        else if (apb.PREADY) begin
          rsp_data_d = apb.PRDATA[DATA_W-1:0];
`ifdef SPI_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        done[grant_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_q       <= '0;
      rsp_data_q <= '0;
      gap_q      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      poll_q     <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_q       <= tx_d;
      rsp_data_q <= rsp_data_d;
      gap_q      <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
      poll_q     <= poll_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

endmodule
